// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the DCM reset/lock supervisor: state encoding,
// default parameter values and sizing helpers.
package dcm_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } dcm_state_t;

    localparam int DEF_RST_CYCLES    = 8;
    localparam int DEF_LOCK_TIMEOUT  = 65536;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_RETRY_MAX     = 3;

    // Number of bits needed to hold values 0 .. value-1 (never less than 1).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    // Largest of three sizes, used to give the shared timer enough range.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        return m;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Double-register the asynchronous input, clearing both stages on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/dcm_reset_ctrl.sv
// Power-up and lock-supervision sequencer for a DCM_SP. Pulses the DCM RST
// pin, qualifies LOCKED, holds the downstream reset until the divided clock
// has been stable, retries a bounded number of times and then latches fail.
module dcm_reset_ctrl
    import dcm_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int RETRY_MAX     = DEF_RETRY_MAX
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dcm_locked,
    input  logic                           dcm_clkin_stopped,
    input  logic                           restart,
    output logic                           dcm_rst,
    output logic                           sys_rst_n,
    output logic                           ready,
    output logic                           fail,
    output logic [clog2(RETRY_MAX+1)-1:0]  retry_cnt
);

    localparam int RC_W    = clog2(RETRY_MAX + 1);
    localparam int TIMER_W = clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES));

    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [RC_W-1:0]    RETRY_LAST  = RC_W'(RETRY_MAX);

    logic               locked_s;
    logic               stopped_s;

    dcm_state_t         state_r;
    dcm_state_t         state_s;
    logic [TIMER_W-1:0] timer_r;
    logic [TIMER_W-1:0] timer_s;
    logic [RC_W-1:0]    retry_cnt_r;
    logic [RC_W-1:0]    retry_cnt_s;
    logic               attempt_fail_s;

    logic               dcm_rst_r;
    logic               sys_rst_n_r;
    logic               ready_r;
    logic               fail_r;

    sync2 u_sync_locked (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dcm_locked),
        .q     (locked_s)
    );

    sync2 u_sync_stopped (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dcm_clkin_stopped),
        .q     (stopped_s)
    );

    // Next-state, retry bookkeeping and shared-timer update.
    always_comb begin
        state_s        = state_r;
        retry_cnt_s    = retry_cnt_r;
        attempt_fail_s = 1'b0;

        if (restart) begin
            state_s     = ST_RESET_HOLD;
            retry_cnt_s = '0;
        end else begin
            case (state_r)
                ST_RESET_HOLD: begin
                    if (timer_r == RST_LAST) begin
                        state_s = ST_WAIT_LOCK;
                    end else begin
                        state_s = ST_RESET_HOLD;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Timeout and clock loss outrank a lock seen the same cycle.
                    if (stopped_s || (timer_r == LOCK_LAST)) begin
                        attempt_fail_s = 1'b1;
                    end else if (locked_s) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_WAIT_LOCK;
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s || stopped_s) begin
                        attempt_fail_s = 1'b1;
                    end else if (timer_r == SETTLE_LAST) begin
                        state_s     = ST_RUN;
                        retry_cnt_s = '0;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end
                ST_RUN: begin
                    // Loss while running restarts without consuming a retry.
                    if (!locked_s || stopped_s) begin
                        state_s = ST_RESET_HOLD;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_s = ST_FAIL;
                end
                default: begin
                    state_s = ST_RESET_HOLD;
                end
            endcase

            // One failed attempt per cycle no matter how many causes coincide.
            if (attempt_fail_s) begin
                if (retry_cnt_r == RETRY_LAST) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s     = ST_RESET_HOLD;
                    retry_cnt_s = retry_cnt_r + RC_W'(1);
                end
            end else begin
                retry_cnt_s = retry_cnt_s;
            end
        end

        if (restart || (state_s != state_r)) begin
            timer_s = '0;
        end else if ((state_r == ST_RESET_HOLD) || (state_r == ST_WAIT_LOCK) ||
                     (state_r == ST_SETTLE)) begin
            timer_s = timer_r + TIMER_W'(1);
        end else begin
            timer_s = '0;
        end
    end

    // State, timer and retry counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RESET_HOLD;
            timer_r     <= '0;
            retry_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            retry_cnt_r <= retry_cnt_s;
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcm_rst_r   <= 1'b1;
            sys_rst_n_r <= 1'b0;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            dcm_rst_r   <= (state_s == ST_RESET_HOLD) || (state_s == ST_FAIL);
            sys_rst_n_r <= (state_s == ST_RUN);
            ready_r     <= (state_s == ST_RUN);
            fail_r      <= (state_s == ST_FAIL);
        end
    end

    assign dcm_rst   = dcm_rst_r;
    assign sys_rst_n = sys_rst_n_r;
    assign ready     = ready_r;
    assign fail      = fail_r;
    assign retry_cnt = retry_cnt_r;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// Scoreboard bench for dcm_reset_ctrl: the stimulus side advances a
// phase/countdown reference model and queues the expected outputs for each
// cycle; a negedge monitor pops and compares them against the DUT.
module tb_dcm_reset_ctrl;

    localparam int RC = 4;    // reset pulse cycles
    localparam int LT = 100;  // lock timeout
    localparam int SC = 8;    // settle cycles
    localparam int RM = 2;    // retries allowed

    logic       clk;
    logic       rst_n;
    logic       dcm_locked;
    logic       dcm_clkin_stopped;
    logic       restart;
    logic       dcm_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;

    int checks   = 0;
    int failures = 0;

    dcm_reset_ctrl #(
        .RST_CYCLES    (RC),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SC),
        .RETRY_MAX     (RM)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .dcm_locked        (dcm_locked),
        .dcm_clkin_stopped (dcm_clkin_stopped),
        .restart           (restart),
        .dcm_rst           (dcm_rst),
        .sys_rst_n         (sys_rst_n),
        .ready             (ready),
        .fail              (fail),
        .retry_cnt         (retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       dcm_rst;
        logic       sys_rst_n;
        logic       ready;
        logic       fail;
        logic [1:0] retry_cnt;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model ----------------
    // Phases: pulse the DCM, wait for lock, settle, run, or dead (gave up).
    typedef enum int {P_PULSE, P_WAIT, P_SETTLE, P_RUN, P_DEAD} phase_t;
    phase_t ph;
    int     remain;
    int     retries;
    bit     lk_d1, lk_d2, st_d1, st_d2;  // input history: one and two edges ago

    function automatic void m_pulse();
        ph     = P_PULSE;
        remain = RC;
    endfunction

    function automatic void m_reset();
        m_pulse();
        retries = 0;
        lk_d1 = 1'b0; lk_d2 = 1'b0; st_d1 = 1'b0; st_d2 = 1'b0;
    endfunction

    function automatic void m_attempt_failed();
        if (retries == RM) begin
            ph = P_DEAD;
        end else begin
            retries = retries + 1;
            m_pulse();
        end
    endfunction

    // Advance one clock edge; lk/st/rs are the input values present at the edge.
    function automatic void m_edge(input bit lk, input bit st, input bit rs);
        bit lock_seen, stop_seen;
        lock_seen = lk_d2;
        stop_seen = st_d2;
        lk_d2 = lk_d1; lk_d1 = lk;
        st_d2 = st_d1; st_d1 = st;
        if (rs) begin
            retries = 0;
            m_pulse();
            return;
        end
        case (ph)
            P_PULSE: begin
                remain = remain - 1;
                if (remain == 0) begin
                    ph = P_WAIT; remain = LT;
                end
            end
            P_WAIT: begin
                remain = remain - 1;
                if (stop_seen || remain == 0) m_attempt_failed();
                else if (lock_seen) begin
                    ph = P_SETTLE; remain = SC;
                end
            end
            P_SETTLE: begin
                remain = remain - 1;
                if (!lock_seen || stop_seen) m_attempt_failed();
                else if (remain == 0) begin
                    ph = P_RUN; retries = 0;
                end
            end
            P_RUN: begin
                if (!lock_seen || stop_seen) m_pulse();
            end
            default: ;
        endcase
    endfunction

    function automatic exp_t m_outputs();
        exp_t e;
        e.dcm_rst   = (ph == P_PULSE) || (ph == P_DEAD);
        e.sys_rst_n = (ph == P_RUN);
        e.ready     = (ph == P_RUN);
        e.fail      = (ph == P_DEAD);
        e.retry_cnt = 2'(retries);
        return e;
    endfunction

    // ---------------- stimulus ----------------
    // One clock: new inputs are applied just after the edge; the model steps
    // over the edge that just happened using the inputs that were held there.
    task automatic cyc(input bit r, input bit lk, input bit st, input bit rs);
        bit o_r, o_lk, o_st, o_rs;
        @(posedge clk);
        #1;
        o_r = rst_n; o_lk = dcm_locked; o_st = dcm_clkin_stopped; o_rs = restart;
        rst_n = r; dcm_locked = lk; dcm_clkin_stopped = st; restart = rs;
        if (!r) m_reset();
        else if (o_r) m_edge(o_lk, o_st, o_rs);
        exp_q.push_back(m_outputs());
    endtask

    task automatic hold(input int n, input bit lk);
        for (int i = 0; i < n; i++) cyc(1'b1, lk, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    bit started = 1'b0;

    // Compare every sampled output set against the oldest queued expectation.
    always @(negedge clk) begin
        if (started) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL queue_underflow t=%0t got=none need=entry", $time);
            end else begin
                exp_t e, a;
                e = exp_q.pop_front();
                a = '{dcm_rst, sys_rst_n, ready, fail, retry_cnt};
                if (a !== e) begin
                    failures = failures + 1;
                    $display("FAIL outputs t=%0t got dcm_rst=%b sys_rst_n=%b ready=%b fail=%b retry_cnt=%0d need dcm_rst=%b sys_rst_n=%b ready=%b fail=%b retry_cnt=%0d",
                             $time, a.dcm_rst, a.sys_rst_n, a.ready, a.fail, a.retry_cnt,
                             e.dcm_rst, e.sys_rst_n, e.ready, e.fail, e.retry_cnt);
                end
            end
        end
    end

    initial begin
        bit lk;
        rst_n = 1'b0; dcm_locked = 1'b0; dcm_clkin_stopped = 1'b0; restart = 1'b0;
        m_reset();
        started = 1'b1;

        // Power-up, lock 20 cycles after release, reach RUN.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        hold(20, 1'b0);
        hold(30, 1'b1);

        // Loss of lock in RUN for one cycle; sequence reruns.
        hold(1, 1'b0);
        hold(40, 1'b1);

        // Lock glitches at a sweep of offsets, including inside SETTLE.
        for (int off = 6; off < 22; off++) begin
            hold(1, 1'b0);
            hold(off, 1'b1);
            hold(1, 1'b0);
            hold(40, 1'b1);
        end

        // Never lock: three attempts, then sticky FAIL.
        hold(3 * (RC + LT) + 40, 1'b0);

        // Restart out of FAIL with lock present.
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        hold(40, 1'b1);

        // Reset asserted mid-SETTLE.
        hold(1, 1'b0);
        hold(10, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        hold(30, 1'b1);

        // Clock-stopped pulse during WAIT_LOCK: a single retry.
        hold(1, 1'b0);
        hold(8, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        hold(20, 1'b0);
        hold(40, 1'b1);

        // Simultaneous stop and timeout at the last WAIT_LOCK cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        hold(RC + LT - 3, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        hold(20, 1'b0);

        // Randomized traffic.
        lk = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) lk = ~lk;
            cyc(($urandom_range(0, 499) != 0), lk,
                ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) == 0));
        end

        @(negedge clk);
        #1;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL queue_drain got=%0d need=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
